// File: rtl/udp_gen_pkg.sv
// -----------------------------------------------------------------------------
// udp_gen_pkg
// Shared constants for the UDP payload generator.
//   MODE_*      : pattern select encodings (3 aliases constant fill)
//   LFSR_TAPS   : tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   SEQ_BYTES   : number of leading payload bytes carrying the sequence number
// -----------------------------------------------------------------------------
package udp_gen_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    localparam logic [7:0] LFSR_TAPS  = 8'hB8;

    localparam int SEQ_BYTES = 4;

    // Left shift with the parity of the tapped bits fed into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/udp_pattern_lfsr.sv
// -----------------------------------------------------------------------------
// udp_pattern_lfsr
// 8-bit Fibonacci LFSR used as the pseudo-random payload pattern.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (state -> SEED)
//   i_load         : reload SEED (wins over i_adv)
//   i_adv          : advance one step
//   o_state        : current state
// -----------------------------------------------------------------------------
module udp_pattern_lfsr
    import udp_gen_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_adv) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/udp_payload_gen.sv
// -----------------------------------------------------------------------------
// udp_payload_gen
// Periodic UDP payload source for the MII transmit path. Pulses tx_go once per
// period and answers nibble requests with a sequence number followed by an
// increment, LFSR or constant-fill pattern.
//   mii_tx_clk : clock
//   rst_n      : asynchronous active-low reset
//   enable     : allows tx_go generation
//   mode       : pattern select, latched at each launch
//   fifo_rq    : nibble request, held high for a contiguous run
//   fifo_da    : registered payload nibble (low nibble of each byte first)
//   tx_go      : one-cycle frame start pulse
//   data_len   : payload length in bytes (constant)
//   seq_num    : sequence number of the current or most recent frame
//
// Request/data handshake: every clock edge that samples fifo_rq=1 consumes one
// nibble and presents it on fifo_da from that edge on (one clock latency);
// edges with fifo_rq=0 rewind to nibble 0 and leave fifo_da unchanged.
// -----------------------------------------------------------------------------
module udp_payload_gen
    import udp_gen_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 20,
    parameter int         PERIOD_CYCLES = 16777216,
    parameter bit         SEQ_EN        = 1'b1,
    parameter logic [7:0] FILL          = 8'hDD,
    parameter logic [7:0] LFSR_SEED     = 8'hFF
) (
    input  logic        mii_tx_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        fifo_rq,
    output logic [3:0]  fifo_da,
    output logic        tx_go,
    output logic [15:0] data_len,
    output logic [31:0] seq_num
);

    localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 2;

    logic [PW-1:0] r_pcnt;
    logic [11:0]   r_nidx;
    logic [1:0]    r_mode_q;
    logic [31:0]   r_seq;
    logic [3:0]    r_fifo_da;
    logic          r_tx_go;

    logic          w_launch;
    logic [10:0]   w_byte_idx;
    logic          w_in_payload;
    logic          w_seq_byte;
    logic [7:0]    w_seq_val;
    logic [7:0]    w_pat_val;
    logic [7:0]    w_byte_val;
    logic [3:0]    w_nibble;
    logic          w_lfsr_adv;
    logic [7:0]    w_lfsr;

    // A launch whose sample lands inside a request run is dropped outright,
    // so a reload can never collide with an LFSR advance.
    assign w_launch     = (r_pcnt == PW'(1)) && enable && !fifo_rq;

    assign w_byte_idx   = r_nidx[11:1];
    assign w_in_payload = (32'(w_byte_idx) < PAYLOAD_BYTES);
    assign w_seq_byte   = SEQ_EN && (32'(w_byte_idx) < SEQ_BYTES);

    // Sequence number goes out big-endian.
    always_comb begin
        w_seq_val = 8'h00;
        case (w_byte_idx[1:0])
            2'd0:    w_seq_val = r_seq[31:24];
            2'd1:    w_seq_val = r_seq[23:16];
            2'd2:    w_seq_val = r_seq[15:8];
            default: w_seq_val = r_seq[7:0];
        endcase
    end

    always_comb begin
        w_pat_val = FILL;
        case (r_mode_q)
            MODE_INC:  w_pat_val = w_byte_idx[7:0];
            MODE_LFSR: w_pat_val = w_lfsr;
            default:   w_pat_val = FILL;
        endcase
    end

    assign w_byte_val = w_seq_byte ? w_seq_val : w_pat_val;
    assign w_nibble   = !w_in_payload ? 4'h0 :
                        (r_nidx[0] ? w_byte_val[7:4] : w_byte_val[3:0]);

    // The LFSR steps after the high nibble of each in-payload pattern byte.
    assign w_lfsr_adv = fifo_rq && r_nidx[0] && w_in_payload && !w_seq_byte;

    udp_pattern_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (mii_tx_clk),
        .i_rst_n (rst_n),
        .i_load  (w_launch),
        .i_adv   (w_lfsr_adv),
        .o_state (w_lfsr)
    );

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt    <= '0;
            r_nidx    <= '0;
            r_mode_q  <= MODE_INC;
            r_seq     <= 32'hFFFF_FFFF;
            r_fifo_da <= 4'h0;
            r_tx_go   <= 1'b0;
        end else begin
            r_pcnt  <= (r_pcnt == PW'(PERIOD_CYCLES - 1)) ? '0 : r_pcnt + PW'(1);
            r_tx_go <= w_launch;

            if (w_launch) begin
                r_mode_q <= mode;
                r_seq    <= r_seq + 32'd1;
            end

            if (fifo_rq) begin
                r_nidx    <= r_nidx + 12'd1;
                r_fifo_da <= w_nibble;
            end else begin
                r_nidx    <= '0;
            end
        end
    end

    assign fifo_da  = r_fifo_da;
    assign tx_go    = r_tx_go;
    assign seq_num  = r_seq;
    assign data_len = 16'(PAYLOAD_BYTES);

endmodule

// File: tb/tb_udp_payload_gen.sv
// -----------------------------------------------------------------------------
// tb_udp_payload_gen
// Two instances share clock, reset and requests: dut_a carries the sequence
// number (increment/constant modes), dut_b has no sequence field and runs the
// LFSR pattern. Period 200 clocks, 20-byte payload.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udp_payload_gen;

    localparam int PB  = 20;
    localparam int PER = 200;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode_a;
    logic [1:0]  mode_b;
    logic        fifo_rq;
    logic [3:0]  da_a, da_b;
    logic        go_a, go_b;
    logic [15:0] len_a, len_b;
    logic [31:0] seq_a, seq_b;

    int checks   = 0;
    int failures = 0;
    int e        = 0;
    logic [3:0] last_a, last_b;

    udp_payload_gen #(
        .PAYLOAD_BYTES (PB),
        .PERIOD_CYCLES (PER),
        .SEQ_EN        (1'b1)
    ) dut_a (
        .mii_tx_clk (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode_a),
        .fifo_rq    (fifo_rq),
        .fifo_da    (da_a),
        .tx_go      (go_a),
        .data_len   (len_a),
        .seq_num    (seq_a)
    );

    udp_payload_gen #(
        .PAYLOAD_BYTES (PB),
        .PERIOD_CYCLES (PER),
        .SEQ_EN        (1'b0)
    ) dut_b (
        .mii_tx_clk (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode_b),
        .fifo_rq    (fifo_rq),
        .fifo_da    (da_b),
        .tx_go      (go_b),
        .data_len   (len_b),
        .seq_num    (seq_b)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle
    task automatic step();
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic step_to(input int target);
        while (e < target) step();
    endtask

    // Drive n requests from the start of a freshly launched frame and check both
    // instances. mfr is the mode dut_a latched at launch; mode_a is switched to
    // constant after nibble switch_at-1 when switch_at > 0.
    task automatic run_frame(input int n, input logic [31:0] seq, input logic [1:0] mfr,
                             input int switch_at, input string pfx);
        logic [7:0] lf;
        logic [7:0] byte_a;
        logic [3:0] exp_a, exp_b;
        int b;
        lf = 8'hFF;
        fifo_rq = 1'b1;
        for (int k = 0; k < n; k++) begin
            b = k / 2;
            if (b < 4)
                byte_a = seq[8*(3-b) +: 8];
            else if (mfr == 2'd0)
                byte_a = b[7:0];
            else
                byte_a = 8'hDD;
            if (b >= PB) begin
                exp_a = 4'h0;
                exp_b = 4'h0;
            end else begin
                exp_a = k[0] ? byte_a[7:4] : byte_a[3:0];
                exp_b = k[0] ? lf[7:4] : lf[3:0];
            end
            step();
            chk($sformatf("%s_a_nib%0d", pfx, k), {28'd0, da_a}, {28'd0, exp_a});
            chk($sformatf("%s_b_nib%0d", pfx, k), {28'd0, da_b}, {28'd0, exp_b});
            last_a = exp_a;
            last_b = exp_b;
            if (k[0] && b < PB)
                lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            if (switch_at > 0 && k + 1 == switch_at)
                mode_a = 2'd2;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        mode_a  = 2'd0;
        mode_b  = 2'd1;
        fifo_rq = 1'b0;
        last_a  = 4'h0;
        last_b  = 4'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_da_a",  {28'd0, da_a}, 32'd0);
        chk("rst_go_a",  {31'd0, go_a}, 32'd0);
        chk("rst_seq_a", seq_a, 32'hFFFF_FFFF);
        chk("rst_len_a", {16'd0, len_a}, 32'd20);
        chk("rst_seq_b", seq_b, 32'hFFFF_FFFF);

        rst_n = 1'b1;
        e = 0;

        // first launch at edge 2
        step();
        chk("e1_go", {31'd0, go_a}, 32'd0);
        chk("e1_seq", seq_a, 32'hFFFF_FFFF);
        step();
        chk("e2_go_a", {31'd0, go_a}, 32'd1);
        chk("e2_go_b", {31'd0, go_b}, 32'd1);
        chk("e2_seq", seq_a, 32'd0);
        step();
        chk("e3_go", {31'd0, go_a}, 32'd0);

        // frame 0: increment / LFSR, 41 requests (last one is overrun)
        run_frame(41, 32'd0, 2'd0, 0, "f0");
        fifo_rq = 1'b0;

        // frame 1: mode switch at nibble 10 ignored until the next launch
        step_to(201);
        chk("e201_go", {31'd0, go_a}, 32'd0);
        step();
        chk("e202_go", {31'd0, go_a}, 32'd1);
        chk("e202_seq", seq_a, 32'd1);
        step();
        chk("e203_go", {31'd0, go_a}, 32'd0);
        run_frame(40, 32'd1, 2'd0, 10, "f1");
        fifo_rq = 1'b0;
        step();
        chk("hold_a", {28'd0, da_a}, {28'd0, last_a});
        chk("hold_b", {28'd0, da_b}, {28'd0, last_b});

        // frame 2: constant fill now in effect
        step_to(402);
        chk("e402_go", {31'd0, go_a}, 32'd1);
        chk("e402_seq", seq_a, 32'd2);
        step();
        run_frame(40, 32'd2, 2'd2, 0, "f2");
        fifo_rq = 1'b0;

        // request held across the launch sample: launch skipped
        step_to(598);
        fifo_rq = 1'b1;
        step_to(602);
        chk("skip_go602", {31'd0, go_a}, 32'd0);
        step();
        chk("skip_go603", {31'd0, go_a}, 32'd0);
        chk("skip_seq", seq_a, 32'd2);
        step_to(605);
        fifo_rq = 1'b0;

        // next launch one period later
        step_to(802);
        chk("e802_go", {31'd0, go_a}, 32'd1);
        chk("e802_seq", seq_a, 32'd3);
        step();

        // reset in the middle of a frame
        run_frame(15, 32'd3, 2'd2, 0, "f3");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_da_a", {28'd0, da_a}, 32'd0);
        chk("mid_rst_da_b", {28'd0, da_b}, 32'd0);
        chk("mid_rst_seq", seq_a, 32'hFFFF_FFFF);
        fifo_rq = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        e = 0;
        step();
        chk("r_e1_go", {31'd0, go_a}, 32'd0);
        step();
        chk("r_e2_go", {31'd0, go_a}, 32'd1);
        chk("r_e2_seq", seq_a, 32'd0);
        step();
        run_frame(12, 32'd0, 2'd2, 0, "f4");
        fifo_rq = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_payload_gen.md
# udp_payload_gen

Parametrised UDP payload source for the MII transmit path. Pulses `tx_go` periodically and answers `udp_protocol`'s nibble requests (`fifo_rq`) with a generated payload. The payload is a 32-bit sequence number followed by a selectable pattern: incrementing, LFSR or constant fill. It replaces hard-coded payload case tables in link test tops.

## Interface
- `PAYLOAD_BYTES`, default 20: payload length in bytes, range 4..1472; driven on `data_len`.
- `PERIOD_CYCLES`, default 16777216: frame launch period in clocks, minimum 2*`PAYLOAD_BYTES`+64.
- `SEQ_EN`, default 1: when 1, bytes 0..3 carry the sequence number; when 0, all bytes carry the pattern.
- `FILL`, default 8'hDD: byte used by constant mode.
- `LFSR_SEED`, default 8'hFF: LFSR state at the start of each frame; must be nonzero.
- `mii_tx_clk`, input, 1: the single clock (25 MHz MII transmit clock). Reset is asynchronous and active-low on `rst_n`.
- `rst_n`, input, 1: asynchronous active-low reset.
- `enable`, input, 1: allows `tx_go` generation.
- `mode`, input, 2: pattern select. 0 = increment, 1 = LFSR, 2 = constant, 3 = constant.
- `fifo_rq`, input, 1: nibble request from `udp_protocol`; held high for a contiguous run.
- `fifo_da`, output, 4: payload nibble.
- `tx_go`, output, 1: one-cycle frame start pulse.
- `data_len`, output, 16: constant `PAYLOAD_BYTES`.
- `seq_num`, output, 32: sequence number of the current or most recent frame.

## Operation
- **Period counter `pcnt`**
  - Counts 0..`PERIOD_CYCLES`-1, then wraps to 0.
  - Free-running regardless of `enable`.
- **Launch**
  - `tx_go` is registered. It is high in the cycle after `pcnt`==1 is sampled with `enable`=1 and `fifo_rq`=0.
  - If `fifo_rq`=1 at that sample, the launch is skipped; the next opportunity is one period later.
- **Per-frame latching at launch**
  - `mode` is latched into `mode_q`.
  - The LFSR is loaded with `LFSR_SEED`.
  - `seq_num` increments by 1, wrapping 32'hFFFFFFFF to 0. The first frame after reset carries 0, so `seq_num` resets to 32'hFFFFFFFF.
- **Nibble index `nidx`** (12 bits)
  - Clears to 0 on any cycle with `fifo_rq`=0.
  - Increments on each edge with `fifo_rq`=1.
  - Byte index = `nidx`[11:1]. Low nibble is sent first (`nidx`[0]=0), then the high nibble.
- **Byte value for byte index b < `PAYLOAD_BYTES`**
  - If `SEQ_EN` and b<4: `seq_num` big-endian, so byte 0 = `seq_num`[31:24].
  - Otherwise, increment mode: b[7:0].
  - Otherwise, LFSR mode: current LFSR state. The LFSR advances once per pattern byte, after its high nibble is issued. Next state = {s[6:0], s[7]^s[5]^s[4]^s[3]} (x^8+x^6+x^5+x^4+1).
  - Otherwise, constant mode: `FILL`.
- **Overrun**: for b >= `PAYLOAD_BYTES`, `fifo_da` = 4'h0 and the LFSR holds.
- **Mid-frame changes**
  - `enable` deasserted mid-frame: the frame completes normally.
  - `mode` changed mid-frame: ignored until the next launch.
- **Reset** (including mid-frame): all state returns to its reset value immediately and the frame is abandoned.

## Timing
- Reset values:
  - `fifo_da`=0, `tx_go`=0, `seq_num`=32'hFFFFFFFF, `data_len`=`PAYLOAD_BYTES`.
  - `pcnt`=0, `nidx`=0, LFSR=`LFSR_SEED`.
- `fifo_da` is registered. The nibble for index k appears on the edge that samples the (k+1)th consecutive `fifo_rq`=1. Latency is one clock from request to data, and `fifo_da` holds while `fifo_rq`=0.
- First `tx_go` after reset release: high during the cycle following the second clock edge (`pcnt`==1), then every `PERIOD_CYCLES` clocks.
- Sequence bytes use the value updated at launch, because launch always precedes `fifo_rq`.

## Structure
- Package `udp_gen_pkg`:
  - mode constants `MODE_INC`, `MODE_LFSR`, `MODE_CONST`;
  - LFSR tap mask 8'hB8;
  - `SEQ_BYTES`=4.
- Sub-module `udp_pattern_lfsr`: 8-bit LFSR with load and advance inputs and an 8-bit state output.
- Period counter, nibble index, byte mux and output register stay in the top.

## Test plan
- `PERIOD_CYCLES`=200, `enable`=1, release reset: `tx_go` pulses at edges 2, 202, 402; `seq_num` reads 0, 1, 2.
- Increment mode, `PAYLOAD_BYTES`=20, `fifo_rq` held 40 cycles after the first launch:
  - nibbles are 0,0,0,0,0,0,0,0, then 4,0, 5,0, …, 3,1 (byte 19 = 0x13);
  - a 41st request yields 0.
- LFSR mode, `SEQ_EN`=0: first bytes FF, FE, FC, F8, F0, E1, giving nibbles F,F, E,F, C,F, 8,F, 0,F, 1,E.
- `fifo_rq` forced high across `pcnt`==1: no `tx_go` that period and `seq_num` is unchanged.
- `mode` switched from 0 to 2 at nibble 10: the frame keeps the increment pattern, and the next frame outputs D,D per byte after the sequence number.
- `rst_n` pulsed low at nibble 15 mid-frame: `fifo_da`=0 and `seq_num`=32'hFFFFFFFF. After release, the first frame again carries sequence 0.
